// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the alu_core block:
//   - default operand / command widths
//   - INP_VALID operand-valid encodings
//   - arithmetic (MODE=1) and logical (MODE=0) command encodings
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int CW_DEFAULT = 4;

    // INP_VALID encodings: bit 0 qualifies OPA, bit 1 qualifies OPB
    localparam logic [1:0] IV_NONE = 2'b00;
    localparam logic [1:0] IV_A    = 2'b01;
    localparam logic [1:0] IV_B    = 2'b10;
    localparam logic [1:0] IV_BOTH = 2'b11;

    typedef enum logic [3:0] {
        A_ADD     = 4'd0,
        A_SUB     = 4'd1,
        A_ADD_CIN = 4'd2,
        A_SUB_CIN = 4'd3,
        A_INC_A   = 4'd4,
        A_DEC_A   = 4'd5,
        A_INC_B   = 4'd6,
        A_DEC_B   = 4'd7,
        A_CMP     = 4'd8,
        A_MUL_INC = 4'd9,
        A_MUL_SHL = 4'd10
    } arith_cmd_e;

    typedef enum logic [3:0] {
        L_AND   = 4'd0,
        L_NAND  = 4'd1,
        L_OR    = 4'd2,
        L_NOR   = 4'd3,
        L_XOR   = 4'd4,
        L_XNOR  = 4'd5,
        L_NOT_A = 4'd6,
        L_NOT_B = 4'd7,
        L_SHR_A = 4'd8,
        L_SHL_A = 4'd9,
        L_SHR_B = 4'd10,
        L_SHL_B = 4'd11,
        L_ROL_A = 4'd12,
        L_ROR_A = 4'd13
    } logic_cmd_e;

endpackage

// File: rtl/alu_mult_stage.sv
// -----------------------------------------------------------------------------
// alu_mult_stage
// First stage of the two-stage multiply path: captures the operands and the
// multiply flavour, and presents the product of the captured operands. The
// second stage is the alu_core output register that samples o_prod.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_ce           : clock enable (0 holds the captured operands)
//   i_load         : capture i_a / i_b / i_shl on this edge
//   i_shl          : 0 -> (A+1)*(B+1), 1 -> ((A<<1) mod 2^DW)*B
//   o_prod         : 2*DW-bit product (truncated) of the captured operands
// -----------------------------------------------------------------------------
module alu_mult_stage
    import alu_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ce,
    input  logic            i_load,
    input  logic            i_shl,
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    output logic [2*DW-1:0] o_prod
);

    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic            r_shl;
    logic [2*DW-1:0] w_a_inc;
    logic [2*DW-1:0] w_b_inc;
    logic [2*DW-1:0] w_a_shl;
    logic [2*DW-1:0] w_b_ext;

    // Operand capture register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_shl <= 1'b0;
        end else if (i_ce && i_load) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_shl <= i_shl;
        end
    end

    // (A+1)*(B+1) can reach 2^(2*DW); the top bit is dropped with the truncation
    assign w_a_inc = {{DW{1'b0}}, r_a} + {{(2*DW-1){1'b0}}, 1'b1};
    assign w_b_inc = {{DW{1'b0}}, r_b} + {{(2*DW-1){1'b0}}, 1'b1};
    assign w_a_shl = {{DW{1'b0}}, r_a[DW-2:0], 1'b0};
    assign w_b_ext = {{DW{1'b0}}, r_b};
    assign o_prod  = r_shl ? (w_a_shl * w_b_ext) : (w_a_inc * w_b_inc);

endmodule

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Registered arithmetic/logic unit. One-cycle latency; multiplies take two.
// Results leave in issue order: an op issued right behind a multiply is
// parked for one cycle in a single-entry slot, and the slot drains on the
// next cycle with no accepted op.
// Optional feature macro: ALU_MULT_EN (arithmetic CMD 9/10 multiplies);
// without it CMD 9/10 are undefined and report ERR.
// Ports:
//   CLK, RST (async active-low), CE (clock enable)
//   INP_VALID[1:0] (bit0 OPA, bit1 OPB), MODE (1 arith / 0 logic), CMD[CW-1:0]
//   OPA, OPB [DW-1:0], CIN
//   RES[2*DW-1:0], COUT, OFLOW, G, L, E, ERR  (all registered)
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE,
    input  logic [1:0]      INP_VALID,
    input  logic            MODE,
    input  logic [CW-1:0]   CMD,
    input  logic [DW-1:0]   OPA,
    input  logic [DW-1:0]   OPB,
    input  logic            CIN,
    output logic [2*DW-1:0] RES,
    output logic            COUT,
    output logic            OFLOW,
    output logic            G,
    output logic            L,
    output logic            E,
    output logic            ERR
);

    localparam int SW = $clog2(DW);

    // Flag vector layout: {COUT, OFLOW, G, L, E, ERR}
    logic [2*DW-1:0] r_res;
    logic [5:0]      r_fl;
    logic            r_slot_v;
    logic            r_slot_mult;
    logic [2*DW-1:0] r_slot_res;
    logic [5:0]      r_slot_fl;

    logic [DW:0]     w_add, w_add_c, w_sub, w_sub_c;
    logic [DW:0]     w_inc_a, w_dec_a, w_inc_b, w_dec_b;
    logic [2*DW-1:0] w_rol, w_ror;
    logic            w_rot_bad;
    logic [2*DW-1:0] w_res;
    logic [DW-1:0]   w_lo;
    logic            w_cout, w_oflow, w_g, w_l, w_e;
    logic            w_undef;
    logic            w_is_mult;
    logic [1:0]      w_need;
    logic            w_bad;
    logic [2*DW-1:0] w_res_f;
    logic [5:0]      w_fl;
    logic            w_mult;
    logic            w_accept;
    logic [2*DW-1:0] w_prod;
    logic [2*DW-1:0] w_slot_res;
    logic [5:0]      w_slot_fl;

    // Borrow is bit DW of each (DW+1)-bit difference
    assign w_add   = {1'b0, OPA} + {1'b0, OPB};
    assign w_add_c = w_add + {{DW{1'b0}}, CIN};
    assign w_sub   = {1'b0, OPA} - {1'b0, OPB};
    assign w_sub_c = w_sub - {{DW{1'b0}}, CIN};
    assign w_inc_a = {1'b0, OPA} + {{DW{1'b0}}, 1'b1};
    assign w_dec_a = {1'b0, OPA} - {{DW{1'b0}}, 1'b1};
    assign w_inc_b = {1'b0, OPB} + {{DW{1'b0}}, 1'b1};
    assign w_dec_b = {1'b0, OPB} - {{DW{1'b0}}, 1'b1};

    // Rotates via a doubled copy of A: ROL keeps the upper half, ROR the lower
    assign w_rol     = {OPA, OPA} << OPB[SW-1:0];
    assign w_ror     = {OPA, OPA} >> OPB[SW-1:0];
    assign w_rot_bad = |OPB[DW-1:SW];
    assign w_accept  = (INP_VALID != IV_NONE);

    // Command decode: raw result, flags and required operands
    always_comb begin
        w_res     = '0;
        w_lo      = '0;
        w_cout    = 1'b0;
        w_oflow   = 1'b0;
        w_g       = 1'b0;
        w_l       = 1'b0;
        w_e       = 1'b0;
        w_undef   = 1'b0;
        w_is_mult = 1'b0;
        w_need    = IV_BOTH;
        if (MODE) begin
            case (CMD)
                CW'(A_ADD):     begin w_res = {{(DW-1){1'b0}}, w_add};   w_cout = w_add[DW];   end
                CW'(A_SUB):     begin w_lo = w_sub[DW-1:0];   w_oflow = w_sub[DW];   end
                CW'(A_ADD_CIN): begin w_res = {{(DW-1){1'b0}}, w_add_c}; w_cout = w_add_c[DW]; end
                CW'(A_SUB_CIN): begin w_lo = w_sub_c[DW-1:0]; w_oflow = w_sub_c[DW]; end
                CW'(A_INC_A):   begin w_res = {{(DW-1){1'b0}}, w_inc_a}; w_cout = w_inc_a[DW]; w_need = IV_A; end
                CW'(A_DEC_A):   begin w_lo = w_dec_a[DW-1:0]; w_oflow = w_dec_a[DW]; w_need = IV_A; end
                CW'(A_INC_B):   begin w_res = {{(DW-1){1'b0}}, w_inc_b}; w_cout = w_inc_b[DW]; w_need = IV_B; end
                CW'(A_DEC_B):   begin w_lo = w_dec_b[DW-1:0]; w_oflow = w_dec_b[DW]; w_need = IV_B; end
                CW'(A_CMP): begin
                    w_g = (OPA > OPB);
                    w_l = (OPA < OPB);
                    w_e = (OPA == OPB);
                end
`ifdef ALU_MULT_EN
                CW'(A_MUL_INC), CW'(A_MUL_SHL): w_is_mult = 1'b1;
`endif
                default: w_undef = 1'b1;
            endcase
        end else begin
            case (CMD)
                CW'(L_AND):   w_lo = OPA & OPB;
                CW'(L_NAND):  w_lo = ~(OPA & OPB);
                CW'(L_OR):    w_lo = OPA | OPB;
                CW'(L_NOR):   w_lo = ~(OPA | OPB);
                CW'(L_XOR):   w_lo = OPA ^ OPB;
                CW'(L_XNOR):  w_lo = ~(OPA ^ OPB);
                CW'(L_NOT_A): begin w_lo = ~OPA;      w_need = IV_A; end
                CW'(L_NOT_B): begin w_lo = ~OPB;      w_need = IV_B; end
                CW'(L_SHR_A): begin w_lo = OPA >> 1;  w_need = IV_A; end
                CW'(L_SHL_A): begin w_lo = OPA << 1;  w_need = IV_A; end
                CW'(L_SHR_B): begin w_lo = OPB >> 1;  w_need = IV_B; end
                CW'(L_SHL_B): begin w_lo = OPB << 1;  w_need = IV_B; end
                CW'(L_ROL_A): begin w_lo = w_rol[2*DW-1:DW]; w_undef = w_rot_bad; end
                CW'(L_ROR_A): begin w_lo = w_ror[DW-1:0];    w_undef = w_rot_bad; end
                default: w_undef = 1'b1;
            endcase
        end
    end

    // Error gating: an illegal op reports ERR alone with a zero result
    always_comb begin
        w_bad = w_undef | ((INP_VALID & w_need) != w_need);
        if (w_bad) begin
            w_res_f = '0;
            w_fl    = 6'b000001;
            w_mult  = 1'b0;
        end else begin
            w_res_f = w_res | {{DW{1'b0}}, w_lo};
            w_fl    = {w_cout, w_oflow, w_g, w_l, w_e, 1'b0};
            w_mult  = w_is_mult;
        end
    end

`ifdef ALU_MULT_EN
    alu_mult_stage #(.DW(DW)) u_mult (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_ce    (CE),
        .i_load  (w_accept & w_mult),
        .i_shl   (CMD == CW'(A_MUL_SHL)),
        .i_a     (OPA),
        .i_b     (OPB),
        .o_prod  (w_prod)
    );
`else
    assign w_prod = '0;
`endif

    // A parked multiply takes its result from the multiplier, not the slot
    assign w_slot_res = r_slot_mult ? w_prod : r_slot_res;
    assign w_slot_fl  = r_slot_mult ? 6'b000000 : r_slot_fl;

    // Output registers and the in-order parking slot
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_res       <= '0;
            r_fl        <= 6'b000000;
            r_slot_v    <= 1'b0;
            r_slot_mult <= 1'b0;
            r_slot_res  <= '0;
            r_slot_fl   <= 6'b000000;
        end else if (CE) begin
            if (w_accept) begin
                if (r_slot_v) begin
                    r_res       <= w_slot_res;
                    r_fl        <= w_slot_fl;
                    r_slot_res  <= w_res_f;
                    r_slot_fl   <= w_fl;
                    r_slot_mult <= w_mult;
                end else if (w_mult) begin
                    r_slot_v    <= 1'b1;
                    r_slot_res  <= w_res_f;
                    r_slot_fl   <= w_fl;
                    r_slot_mult <= 1'b1;
                end else begin
                    r_res <= w_res_f;
                    r_fl  <= w_fl;
                end
            end else if (r_slot_v) begin
                r_res       <= w_slot_res;
                r_fl        <= w_slot_fl;
                r_slot_v    <= 1'b0;
                r_slot_mult <= 1'b0;
            end
        end
    end

    assign RES                          = r_res;
    assign {COUT, OFLOW, G, L, E, ERR}  = r_fl;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          CE;
    logic [1:0]    INP_VALID;
    logic          MODE;
    logic [CW-1:0] CMD;
    logic [DW-1:0] OPA;
    logic [DW-1:0] OPB;
    logic          CIN;
    logic [2*DW-1:0] RES;
    logic          COUT, OFLOW, G, L, E, ERR;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] res;
        logic        cout, oflow, g, l, e, err;
        bit          mult;
    } exp_t;

    always #5 CLK = ~CLK;

    alu_core #(.DW(DW), .CW(CW)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE),
        .CMD(CMD), .OPA(OPA), .OPB(OPB), .CIN(CIN),
        .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .L(L), .E(E), .ERR(ERR)
    );

    // Reference model: the operation table with plain integer arithmetic
    function automatic exp_t model(logic [1:0] iv, logic mode, logic [3:0] cmd,
                                   logic [7:0] opa, logic [7:0] opb, logic cin);
        exp_t e;
        int a, b, c, r;
        bit undef, needa, needb;
        e = '{default: 0};
        a = int'(opa); b = int'(opb); c = int'(cin);
        r = 0; undef = 0; needa = 1; needb = 1;
        if (mode) begin
            case (cmd)
                4'd0: begin r = a + b;     e.res = 16'(r);       e.cout  = (r > 255); end
                4'd1: begin r = a - b;     e.res = 16'(r & 255); e.oflow = (r < 0);   end
                4'd2: begin r = a + b + c; e.res = 16'(r);       e.cout  = (r > 255); end
                4'd3: begin r = a - b - c; e.res = 16'(r & 255); e.oflow = (r < 0);   end
                4'd4: begin needb = 0; r = a + 1; e.res = 16'(r);       e.cout  = (r > 255); end
                4'd5: begin needb = 0; r = a - 1; e.res = 16'(r & 255); e.oflow = (r < 0);   end
                4'd6: begin needa = 0; r = b + 1; e.res = 16'(r);       e.cout  = (r > 255); end
                4'd7: begin needa = 0; r = b - 1; e.res = 16'(r & 255); e.oflow = (r < 0);   end
                4'd8: begin e.g = (a > b); e.l = (a < b); e.e = (a == b); end
`ifdef ALU_MULT_EN
                4'd9:  begin e.res = 16'((a + 1) * (b + 1));      e.mult = 1; end
                4'd10: begin e.res = 16'(((a * 2) & 255) * b);    e.mult = 1; end
`endif
                default: undef = 1;
            endcase
        end else begin
            case (cmd)
                4'd0:  r = a & b;
                4'd1:  r = ~(a & b) & 255;
                4'd2:  r = a | b;
                4'd3:  r = ~(a | b) & 255;
                4'd4:  r = a ^ b;
                4'd5:  r = ~(a ^ b) & 255;
                4'd6:  begin needb = 0; r = ~a & 255; end
                4'd7:  begin needa = 0; r = ~b & 255; end
                4'd8:  begin needb = 0; r = a / 2; end
                4'd9:  begin needb = 0; r = (a * 2) & 255; end
                4'd10: begin needa = 0; r = b / 2; end
                4'd11: begin needa = 0; r = (b * 2) & 255; end
                4'd12: if (b > 7) undef = 1; else r = ((a << b) | (a >> (8 - b))) & 255;
                4'd13: if (b > 7) undef = 1; else r = ((a >> b) | (a << (8 - b))) & 255;
                default: undef = 1;
            endcase
            e.res = 16'(r);
        end
        if (undef || (needa && !iv[0]) || (needb && !iv[1])) begin
            e = '{default: 0};
            e.err = 1;
        end
        return e;
    endfunction

    task automatic drive(input logic [1:0] iv, input logic mode, input logic [3:0] cmd,
                         input logic [7:0] a, input logic [7:0] b, input logic cin);
        INP_VALID = iv; MODE = mode; CMD = cmd; OPA = a; OPB = b; CIN = cin;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0; CE = 1'b1;
        drive(2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
        #12;
        checks++;
        if (RES !== 16'h0 || {COUT, OFLOW, G, L, E, ERR} !== 6'b0) begin
            errors++;
            $display("FAIL reset_init: RES=%h flags=%b, expected 0000 / 000000", RES, {COUT, OFLOW, G, L, E, ERR});
        end
        @(negedge CLK); RST = 1'b1;
        drive(2'b11, 1'b1, 4'd0, 8'h10, 8'h22, 1'b0);
        tick();
        checks++;
        if (RES !== 16'h0032) begin
            errors++; $display("FAIL pre_reset_add: RES=%h expected 0032", RES);
        end
        drive(2'b11, 1'b1, 4'd1, 8'h05, 8'h07, 1'b0);
        #3; RST = 1'b0; #1;
        checks++;
        if (RES !== 16'h0 || {COUT, OFLOW, G, L, E, ERR} !== 6'b0) begin
            errors++;
            $display("FAIL reset_async: RES=%h flags=%b, expected 0000 / 000000", RES, {COUT, OFLOW, G, L, E, ERR});
        end
        tick();
        checks++;
        if (RES !== 16'h0 || {COUT, OFLOW, G, L, E, ERR} !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold: RES=%h flags=%b, expected 0000 / 000000", RES, {COUT, OFLOW, G, L, E, ERR});
        end
        #2; RST = 1'b1;
    endtask

    task automatic test_add();
        drive(2'b11, 1'b1, 4'd0, 8'hFF, 8'h01, 1'b0);
        tick();
        checks++;
        if (RES !== 16'h0100 || COUT !== 1'b1 || ERR !== 1'b0 || OFLOW !== 1'b0) begin
            errors++; $display("FAIL add_carry: RES=%h COUT=%b ERR=%b, expected 0100 1 0", RES, COUT, ERR);
        end
    endtask

    task automatic test_sub_cmp();
        drive(2'b11, 1'b1, 4'd1, 8'h05, 8'h07, 1'b0);
        tick();
        checks++;
        if (RES !== 16'h00FE || OFLOW !== 1'b1 || COUT !== 1'b0 || ERR !== 1'b0) begin
            errors++; $display("FAIL sub_borrow: RES=%h OFLOW=%b, expected 00fe 1", RES, OFLOW);
        end
        drive(2'b11, 1'b1, 4'd8, 8'h10, 8'h20, 1'b0);
        tick();
        checks++;
        if (RES !== 16'h0 || {G, L, E} !== 3'b010 || OFLOW !== 1'b0) begin
            errors++; $display("FAIL cmp_less: RES=%h GLE=%b, expected 0000 010", RES, {G, L, E});
        end
        drive(2'b11, 1'b1, 4'd8, 8'h33, 8'h33, 1'b0);
        tick();
        checks++;
        if (RES !== 16'h0 || {G, L, E} !== 3'b001) begin
            errors++; $display("FAIL cmp_equal: RES=%h GLE=%b, expected 0000 001", RES, {G, L, E});
        end
    endtask

    task automatic test_mult();
`ifdef ALU_MULT_EN
        drive(2'b11, 1'b1, 4'd9, 8'd3, 8'd4, 1'b0);
        tick();
        drive(2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
        checks++;
        if (RES !== 16'h0 || E !== 1'b1) begin
            errors++; $display("FAIL mult_not_early: RES=%h E=%b, expected 0000 1", RES, E);
        end
        tick();
        checks++;
        if (RES !== 16'd20 || ERR !== 1'b0 || {G, L, E} !== 3'b000) begin
            errors++; $display("FAIL mult_inc: RES=%0d ERR=%b, expected 20 0", RES, ERR);
        end
        drive(2'b11, 1'b1, 4'd10, 8'h81, 8'h03, 1'b0);
        tick(); tick();
        checks++;
        if (RES !== 16'd6) begin
            errors++; $display("FAIL mult_shl: RES=%0d expected 6", RES);
        end
        // reset between capture and result aborts the multiply
        drive(2'b11, 1'b1, 4'd9, 8'd7, 8'd7, 1'b0);
        tick();
        drive(2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
        RST = 1'b0; #2; RST = 1'b1;
        tick();
        checks++;
        if (RES !== 16'h0 || ERR !== 1'b0) begin
            errors++; $display("FAIL mult_abort: RES=%h expected 0000", RES);
        end
`else
        drive(2'b11, 1'b1, 4'd9, 8'd3, 8'd4, 1'b0);
        tick();
        checks++;
        if (RES !== 16'h0 || ERR !== 1'b1) begin
            errors++; $display("FAIL mult_disabled: RES=%h ERR=%b, expected 0000 1", RES, ERR);
        end
`endif
    endtask

    task automatic test_rotate();
        drive(2'b11, 1'b0, 4'd12, 8'h81, 8'h01, 1'b0);
        tick();
        checks++;
        if (RES !== 16'h0003 || ERR !== 1'b0) begin
            errors++; $display("FAIL rol: RES=%h ERR=%b, expected 0003 0", RES, ERR);
        end
        drive(2'b11, 1'b0, 4'd13, 8'h81, 8'h01, 1'b0);
        tick();
        checks++;
        if (RES !== 16'h00C0 || ERR !== 1'b0) begin
            errors++; $display("FAIL ror: RES=%h ERR=%b, expected 00c0 0", RES, ERR);
        end
        drive(2'b11, 1'b0, 4'd12, 8'h81, 8'h13, 1'b0);
        tick();
        checks++;
        if (RES !== 16'h0 || ERR !== 1'b1) begin
            errors++; $display("FAIL rol_bad_amount: RES=%h ERR=%b, expected 0000 1", RES, ERR);
        end
    endtask

    task automatic test_err_ce();
        drive(2'b01, 1'b1, 4'd0, 8'h12, 8'h34, 1'b0);
        tick();
        checks++;
        if (RES !== 16'h0 || ERR !== 1'b1) begin
            errors++; $display("FAIL missing_operand: RES=%h ERR=%b, expected 0000 1", RES, ERR);
        end
        drive(2'b11, 1'b1, 4'd0, 8'h12, 8'h34, 1'b0);
        tick();
        checks++;
        if (RES !== 16'h0046 || ERR !== 1'b0) begin
            errors++; $display("FAIL add_plain: RES=%h expected 0046", RES);
        end
        CE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'b1);
            tick();
            checks++;
            if (RES !== 16'h0046 || {COUT, OFLOW, G, L, E, ERR} !== 6'b0) begin
                errors++; $display("FAIL ce_hold: RES=%h flags=%b, expected 0046 000000", RES, {COUT, OFLOW, G, L, E, ERR});
            end
        end
        CE = 1'b1;
        drive(2'b00, 1'b1, 4'd1, 8'hAA, 8'h55, 1'b0);
        tick();
        checks++;
        if (RES !== 16'h0046 || ERR !== 1'b0) begin
            errors++; $display("FAIL no_op_hold: RES=%h expected 0046", RES);
        end
    endtask

    task automatic test_back_to_back();
`ifdef ALU_MULT_EN
        logic [15:0] want [4] = '{16'h0046, 16'd30, 16'd3, 16'd5};
        drive(2'b11, 1'b1, 4'd9, 8'd4, 8'd5, 1'b0);
        tick();
        drive(2'b11, 1'b1, 4'd0, 8'd1, 8'd2, 1'b0);
        checks++;
        if (RES !== want[0]) begin errors++; $display("FAIL b2b_0: RES=%h expected %h", RES, want[0]); end
        tick();
        drive(2'b11, 1'b1, 4'd1, 8'd9, 8'd4, 1'b0);
        checks++;
        if (RES !== want[1]) begin errors++; $display("FAIL b2b_1: RES=%h expected %h", RES, want[1]); end
        tick();
        drive(2'b00, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
        checks++;
        if (RES !== want[2]) begin errors++; $display("FAIL b2b_2: RES=%h expected %h", RES, want[2]); end
        tick();
        checks++;
        if (RES !== want[3]) begin errors++; $display("FAIL b2b_3: RES=%h expected %h", RES, want[3]); end
`else
        drive(2'b11, 1'b1, 4'd0, 8'd1, 8'd2, 1'b0);
        tick();
        drive(2'b11, 1'b1, 4'd1, 8'd9, 8'd4, 1'b0);
        checks++;
        if (RES !== 16'd3) begin errors++; $display("FAIL b2b_0: RES=%h expected 0003", RES); end
        tick();
        checks++;
        if (RES !== 16'd5) begin errors++; $display("FAIL b2b_1: RES=%h expected 0005", RES); end
`endif
    endtask

    // Random stream; results scheduled in issue order at max(natural edge, previous+1)
    task automatic test_random();
        exp_t cur, e, q[$];
        int   qs[$];
        int   k, last, nat, s;
        logic [1:0] iv;
        logic mode, cin, ce;
        logic [3:0] cmd;
        logic [7:0] a, b;
        RST = 1'b0; #2; RST = 1'b1;
        cur = '{default: 0};
        k = 0; last = -1;
        for (int i = 0; i < 400; i++) begin
            ce   = ($urandom_range(0, 9) != 0);
            s    = $urandom_range(0, 7);
            iv   = (s == 0) ? 2'b00 : (s == 1) ? 2'b01 : (s == 2) ? 2'b10 : 2'b11;
            mode = 1'($urandom_range(0, 1));
            cmd  = 4'($urandom_range(0, 15));
            a    = 8'($urandom);
            b    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            cin  = 1'($urandom_range(0, 1));
            CE = ce;
            drive(iv, mode, cmd, a, b, cin);
            tick();
            if (ce) begin
                k++;
                if (iv != 2'b00) begin
                    e   = model(iv, mode, cmd, a, b, cin);
                    nat = e.mult ? k + 1 : k;
                    s   = (nat > last) ? nat : last + 1;
                    last = s;
                    q.push_back(e);
                    qs.push_back(s);
                end
                if (qs.size() > 0 && qs[0] == k) begin
                    cur = q.pop_front();
                    void'(qs.pop_front());
                end
            end
            checks++;
            if ({RES, COUT, OFLOW, G, L, E, ERR} !== {cur.res, cur.cout, cur.oflow, cur.g, cur.l, cur.e, cur.err}) begin
                errors++;
                $display("FAIL random[%0d] mode=%b cmd=%0d iv=%b a=%h b=%h: RES=%h flags=%b expected RES=%h flags=%b",
                         i, mode, cmd, iv, a, b, RES, {COUT, OFLOW, G, L, E, ERR},
                         cur.res, {cur.cout, cur.oflow, cur.g, cur.l, cur.e, cur.err});
            end
        end
        CE = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_cmp();
        test_mult();
        test_rotate();
        test_err_ce();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
